// File: rtl/call_return_ctrl.sv
// Call/return sequencer sitting between the control unit and the data stack.
// Converts single-cycle CALL/RET requests into one-cycle write/read strobes,
// tracks stack occupancy, returns the popped address with a one-cycle valid
// pulse and blocks/flags overflow, underflow and conflicting requests.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for call/ret; only state in which requests are seen
//   PUSH   | stk_write high for this cycle; count increments at its end
//   POP    | stk_read high for this cycle; count decrements at its end
//   WAIT   | counting down the stack read latency before capturing data
//   DONE   | ret_valid high for this cycle, ret_addr holds popped value

module call_return_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         call,
    input  logic                         ret,
    input  logic [DATA_W-1:0]            pc_next,
    output logic                         busy,
    output logic                         ret_valid,
    output logic [DATA_W-1:0]            ret_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    output logic                         illegal,
    output logic                         stk_write,
    output logic                         stk_read,
    output logic [DATA_W-1:0]            stk_data_in,
    input  logic [DATA_W-1:0]            stk_data_out
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // A latency of 1 still needs a one-bit counter so the WAIT state has
    // a uniform "count down to zero" behaviour for every RD_LAT.
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PUSH = 3'd1,
        S_POP  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [LAT_W-1:0]    lat_q;
    logic [LAT_W-1:0]    lat_d;

    logic                busy_d;
    logic                ret_valid_d;
    logic [DATA_W-1:0]   ret_addr_d;
    logic [CNT_W-1:0]    count_d;
    logic                overflow_d;
    logic                underflow_d;
    logic                illegal_d;
    logic                stk_write_d;
    logic                stk_read_d;
    logic [DATA_W-1:0]   stk_data_in_d;

    logic                cnt_full;
    logic                cnt_empty;

    assign cnt_full  = (count == CNT_FULL);
    assign cnt_empty = (count == '0);

    // Next-state and next-output decode; every output is registered below,
    // so strobes here describe the state being entered, not the current one.
    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        ret_valid_d   = 1'b0;
        stk_write_d   = 1'b0;
        stk_read_d    = 1'b0;
        ret_addr_d    = ret_addr;
        count_d       = count;
        overflow_d    = overflow;
        underflow_d   = underflow;
        illegal_d     = illegal;
        stk_data_in_d = stk_data_in;

        case (state_q)
            S_IDLE: begin
                if (call && ret) begin
                    illegal_d = 1'b1;
                end else if (call) begin
                    if (cnt_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        stk_data_in_d = pc_next;
                        stk_write_d   = 1'b1;
                        state_d       = S_PUSH;
                    end
                end else if (ret) begin
                    if (cnt_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        stk_read_d = 1'b1;
                        state_d    = S_POP;
                    end
                end
            end

            S_PUSH: begin
                // Guarded so occupancy can never pass DEPTH even if the
                // state were entered abnormally.
                if (!cnt_full) begin
                    count_d = count + CNT_ONE;
                end
                state_d = S_IDLE;
            end

            S_POP: begin
                if (!cnt_empty) begin
                    count_d = count - CNT_ONE;
                end
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (lat_q == '0) begin
                    ret_addr_d  = stk_data_out;
                    ret_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    // and treats the stack as logically empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lat_q       <= '0;
            busy        <= 1'b0;
            ret_valid   <= 1'b0;
            ret_addr    <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            illegal     <= 1'b0;
            stk_write   <= 1'b0;
            stk_read    <= 1'b0;
            stk_data_in <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            busy        <= busy_d;
            ret_valid   <= ret_valid_d;
            ret_addr    <= ret_addr_d;
            count       <= count_d;
            overflow    <= overflow_d;
            underflow   <= underflow_d;
            illegal     <= illegal_d;
            stk_write   <= stk_write_d;
            stk_read    <= stk_read_d;
            stk_data_in <= stk_data_in_d;
        end
    end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Bench for call_return_ctrl: a fixed vector table, hand-written multi-cycle
// corner sequences, and a random request stream compared against a
// queue-based model of a return-address stack.

module tb_call_return_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int RD_LAT = 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int RV_IDX = RD_LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic [DATA_W-1:0] pc_next = '0;
    logic              busy;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_addr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              illegal;
    logic              stk_write;
    logic              stk_read;
    logic [DATA_W-1:0] stk_data_in;
    logic [DATA_W-1:0] stk_data_out = '0;

    int checks = 0;
    int failures = 0;
    int wr_total = 0;

    call_return_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .pc_next(pc_next),
        .busy(busy), .ret_valid(ret_valid), .ret_addr(ret_addr), .count(count),
        .overflow(overflow), .underflow(underflow), .illegal(illegal),
        .stk_write(stk_write), .stk_read(stk_read),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out)
    );

    always #5 clk = ~clk;

    // Stack model with a one-cycle registered read port.
    logic [DATA_W-1:0] mem [DEPTH];
    int sp = 0;
    always @(posedge clk) begin
        if (reset) begin
            sp <= 0;
        end else if (stk_write) begin
            if (sp < DEPTH) begin
                mem[sp] <= stk_data_in;
                sp <= sp + 1;
            end
        end else if (stk_read) begin
            if (sp > 0) begin
                stk_data_out <= mem[sp-1];
                sp <= sp - 1;
            end
        end
    end

    always @(posedge clk) if (stk_write) wr_total <= wr_total + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            check("strobe_excl", 32'(stk_write & stk_read), 32'd0);
            check("count_bound", 32'(count > CNT_W'(DEPTH)), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        bit          c;
        bit          r;
        logic [31:0] pc;
        int          wr;
        int          rd;
        int          rv_idx;
        int          bsy;
        logic [31:0] addr;
        logic [31:0] din;
        int          cnt;
        logic [2:0]  flg;
    } vec_t;

    function automatic vec_t mk(bit c, bit r, logic [31:0] pc, int wr, int rd, int rv_idx,
                                int bsy, logic [31:0] addr, logic [31:0] din, int cnt,
                                logic [2:0] flg);
        vec_t v;
        v.c = c; v.r = r; v.pc = pc; v.wr = wr; v.rd = rd; v.rv_idx = rv_idx;
        v.bsy = bsy; v.addr = addr; v.din = din; v.cnt = cnt; v.flg = flg;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        call = 1'b0;
        ret = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_ctrl", 32'({busy, ret_valid, stk_write, stk_read}), 32'd0);
        check("reset_flags", 32'({overflow, underflow, illegal}), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_ret_addr", ret_addr, 32'd0);
        check("reset_data_in", stk_data_in, 32'd0);
    endtask

    // Drives one request for one cycle and watches until busy drops.
    task automatic issue(input bit c, input bit r, input logic [31:0] pc,
                         output int n_wr, output int n_rd, output int n_rv,
                         output int rv_idx, output int n_busy, output logic [31:0] wdata);
        n_wr = 0; n_rd = 0; n_rv = 0; rv_idx = 0; n_busy = 0; wdata = '0;
        call = c;
        ret = r;
        pc_next = pc;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) begin
                call = 1'b0;
                ret = 1'b0;
            end
            if (stk_write) begin
                n_wr++;
                wdata = stk_data_in;
            end
            if (stk_read) n_rd++;
            if (ret_valid) begin
                n_rv++;
                if (rv_idx == 0) rv_idx = i;
            end
            if (!busy) break;
            n_busy++;
        end
    endtask

    vec_t tbl[15];

    initial begin
        int n_wr, n_rd, n_rv, rv_idx, n_busy, wr_before;
        logic [31:0] wdata;
        logic [31:0] q[$];
        logic [31:0] m_addr, m_din;
        bit m_ovf, m_unf, m_ill;

        tbl[0]  = mk(1, 0, 32'h12345678, 1, 0, 0, 1, 32'h0,        32'h12345678, 1, 3'b000);
        tbl[1]  = mk(1, 0, 32'hAABBCCDD, 1, 0, 0, 1, 32'h0,        32'hAABBCCDD, 2, 3'b000);
        tbl[2]  = mk(1, 0, 32'h11223344, 1, 0, 0, 1, 32'h0,        32'h11223344, 3, 3'b000);
        tbl[3]  = mk(0, 1, 32'h0,        0, 1, RV_IDX, 3, 32'h11223344, 32'h11223344, 2, 3'b000);
        tbl[4]  = mk(0, 1, 32'h0,        0, 1, RV_IDX, 3, 32'hAABBCCDD, 32'h11223344, 1, 3'b000);
        tbl[5]  = mk(0, 1, 32'h0,        0, 1, RV_IDX, 3, 32'h12345678, 32'h11223344, 0, 3'b000);
        tbl[6]  = mk(0, 1, 32'h0,        0, 0, 0, 0, 32'h12345678, 32'h11223344, 0, 3'b010);
        tbl[7]  = mk(1, 1, 32'h99999999, 0, 0, 0, 0, 32'h12345678, 32'h11223344, 0, 3'b011);
        tbl[8]  = mk(1, 0, 32'hDEAD0001, 1, 0, 0, 1, 32'h12345678, 32'hDEAD0001, 1, 3'b011);
        tbl[9]  = mk(1, 0, 32'hDEAD0002, 1, 0, 0, 1, 32'h12345678, 32'hDEAD0002, 2, 3'b011);
        tbl[10] = mk(1, 0, 32'hDEAD0003, 1, 0, 0, 1, 32'h12345678, 32'hDEAD0003, 3, 3'b011);
        tbl[11] = mk(1, 0, 32'hDEAD0004, 1, 0, 0, 1, 32'h12345678, 32'hDEAD0004, 4, 3'b011);
        tbl[12] = mk(1, 0, 32'hCAFEF00D, 0, 0, 0, 0, 32'h12345678, 32'hDEAD0004, 4, 3'b111);
        tbl[13] = mk(0, 1, 32'h0,        0, 1, RV_IDX, 3, 32'hDEAD0004, 32'hDEAD0004, 3, 3'b111);
        tbl[14] = mk(0, 1, 32'h0,        0, 1, RV_IDX, 3, 32'hDEAD0003, 32'hDEAD0004, 2, 3'b111);

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].c, tbl[i].r, tbl[i].pc, n_wr, n_rd, n_rv, rv_idx, n_busy, wdata);
            check($sformatf("vec%0d_writes", i), 32'(n_wr), 32'(tbl[i].wr));
            check($sformatf("vec%0d_reads", i), 32'(n_rd), 32'(tbl[i].rd));
            check($sformatf("vec%0d_rv_count", i), 32'(n_rv), 32'(tbl[i].rv_idx != 0));
            check($sformatf("vec%0d_rv_cycle", i), 32'(rv_idx), 32'(tbl[i].rv_idx));
            check($sformatf("vec%0d_busy_cycles", i), 32'(n_busy), 32'(tbl[i].bsy));
            check($sformatf("vec%0d_ret_addr", i), ret_addr, tbl[i].addr);
            check($sformatf("vec%0d_data_in", i), stk_data_in, tbl[i].din);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_flags", i), 32'({overflow, underflow, illegal}), 32'(tbl[i].flg));
            if (tbl[i].wr != 0)
                check($sformatf("vec%0d_write_data", i), wdata, tbl[i].pc);
        end

        // Requests held high while busy are ignored.
        do_reset();
        wr_before = wr_total;
        call = 1'b1;
        pc_next = 32'hA1A1A1A1;
        @(negedge clk);
        check("busy_call_busy", 32'(busy), 32'd1);
        check("busy_call_write", 32'(stk_write), 32'd1);
        pc_next = 32'hB2B2B2B2;
        @(negedge clk);
        call = 1'b0;
        check("busy_call_count", 32'(count), 32'd1);
        check("busy_call_din", stk_data_in, 32'hA1A1A1A1);
        check("busy_call_idle", 32'({busy, stk_write}), 32'd0);
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        call = 1'b1;
        pc_next = 32'hC3C3C3C3;
        @(negedge clk);
        @(negedge clk);
        check("busy_ret_valid", 32'(ret_valid), 32'd1);
        check("busy_ret_addr", ret_addr, 32'hA1A1A1A1);
        call = 1'b0;
        @(negedge clk);
        check("busy_ret_idle", 32'(busy), 32'd0);
        check("busy_ret_count", 32'(count), 32'd0);
        check("busy_ret_din", stk_data_in, 32'hA1A1A1A1);
        check("busy_total_writes", 32'(wr_total - wr_before), 32'd1);

        // Reset landing in the WAIT cycle aborts the pop.
        do_reset();
        issue(1'b1, 1'b0, 32'h5A5A5A5A, n_wr, n_rd, n_rv, rv_idx, n_busy, wdata);
        ret = 1'b1;
        @(negedge clk);
        ret = 1'b0;
        check("rstwait_read", 32'(stk_read), 32'd1);
        @(negedge clk);
        check("rstwait_in_wait", 32'({busy, ret_valid, stk_read}), 32'b100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstwait_ctrl", 32'({busy, ret_valid, stk_write, stk_read}), 32'd0);
        check("rstwait_data", ret_addr | stk_data_in, 32'd0);
        check("rstwait_count_flags", 32'({count, overflow, underflow, illegal}), 32'd0);
        @(negedge clk);
        check("rstwait_no_valid", 32'({busy, ret_valid}), 32'd0);
        issue(1'b0, 1'b1, 32'h0, n_wr, n_rd, n_rv, rv_idx, n_busy, wdata);
        check("rstwait_ret_reads", 32'(n_rd), 32'd0);
        check("rstwait_ret_rv", 32'(n_rv), 32'd0);
        check("rstwait_underflow", 32'(underflow), 32'd1);
        check("rstwait_count", 32'(count), 32'd0);

        // Random request stream against a queue model of the return stack.
        do_reset();
        q.delete();
        m_addr = '0; m_din = '0; m_ovf = 0; m_unf = 0; m_ill = 0;
        for (int k = 0; k < 200; k++) begin
            int sel;
            bit c, r;
            int e_wr, e_rd, e_rv, e_busy;
            logic [31:0] pc;
            sel = int'($urandom_range(0, 9));
            pc = $urandom;
            c = (sel <= 3) || (sel == 8);
            r = (sel >= 4 && sel <= 8);
            e_wr = 0; e_rd = 0; e_rv = 0; e_busy = 0;
            if (c && r) begin
                m_ill = 1;
            end else if (c) begin
                if (q.size() == DEPTH) begin
                    m_ovf = 1;
                end else begin
                    q.push_back(pc);
                    m_din = pc;
                    e_wr = 1;
                    e_busy = 1;
                end
            end else if (r) begin
                if (q.size() == 0) begin
                    m_unf = 1;
                end else begin
                    m_addr = q.pop_back();
                    e_rd = 1;
                    e_rv = 1;
                    e_busy = RD_LAT + 2;
                end
            end
            issue(c, r, pc, n_wr, n_rd, n_rv, rv_idx, n_busy, wdata);
            check("rnd_writes", 32'(n_wr), 32'(e_wr));
            check("rnd_reads", 32'(n_rd), 32'(e_rd));
            check("rnd_rv_count", 32'(n_rv), 32'(e_rv));
            check("rnd_busy_cycles", 32'(n_busy), 32'(e_busy));
            if (e_rv != 0) check("rnd_rv_cycle", 32'(rv_idx), 32'(RV_IDX));
            check("rnd_count", 32'(count), 32'(q.size()));
            check("rnd_ret_addr", ret_addr, m_addr);
            check("rnd_data_in", stk_data_in, m_din);
            check("rnd_flags", 32'({overflow, underflow, illegal}), 32'({m_ovf, m_unf, m_ill}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_return_ctrl.md
# call_return_ctrl

Call/return sequencer between the control unit and the 32-bit data `Stack` (`clk`, `write`, `read`, `data_in`, `data_out`). It turns single-cycle CALL/RET requests from the control unit into correctly timed `write`/`read` strobes on the stack. It keeps its own occupancy count and returns the popped return address to the PC mux with a one-cycle valid pulse. Overflow, underflow and illegal requests are blocked before they reach the stack and are reported as sticky flags.

## Interface
Parameters:
- `DATA_W`, 32 — return-address / stack word width
- `DEPTH`, 32 — stack capacity in entries
- `RD_LAT`, 1 — cycles from the stack sampling `read` to `data_out` being valid (≥1)

Ports:
- `clk`  in  1  — single clock, rising edge
- `reset`  in  1  — synchronous, active-high
- `call`  in  1  — push request, sampled in IDLE only
- `ret`  in  1  — pop request, sampled in IDLE only
- `pc_next`  in  DATA_W  — return address to push, captured with `call`
- `busy`  out  1  — high in every state except IDLE; requests ignored while high
- `ret_valid`  out  1  — one-cycle pulse, `ret_addr` valid
- `ret_addr`  out  DATA_W  — popped address, held until next pop
- `count`  out  $clog2(DEPTH+1)  — entries on stack
- `overflow`  out  1  — sticky: a CALL was attempted while full
- `underflow`  out  1  — sticky: a RET was attempted while empty
- `illegal`  out  1  — sticky: `call` and `ret` were high together
- `stk_write`  out  1  — drives Stack `write`
- `stk_read`  out  1  — drives Stack `read`
- `stk_data_in`  out  DATA_W  — drives Stack `data_in`
- `stk_data_out`  in  DATA_W  — from Stack `data_out`

## Operation
- States: IDLE, PUSH, POP, WAIT, DONE. All outputs are registered.
- IDLE, `call` only:
  - count < DEPTH → latch `pc_next` into `stk_data_in`, go to PUSH.
  - count == DEPTH → set `overflow`, stay in IDLE, no strobe.
- IDLE, `ret` only:
  - count > 0 → go to POP.
  - count == 0 → set `underflow`, stay in IDLE, no strobe, no `ret_valid`.
- IDLE, `call` and `ret` both high → set `illegal`, no action.
- PUSH:
  - `stk_write`=1 for exactly one cycle.
  - count+1 at the end of the cycle.
  - → IDLE.
- POP:
  - `stk_read`=1 for exactly one cycle.
  - count−1 at the end of the cycle.
  - Latency counter loads RD_LAT−1.
  - → WAIT.
- WAIT:
  - Counter decrements each cycle.
  - At 0, capture `stk_data_out` into `ret_addr` and go to DONE.
- DONE: `ret_valid`=1 for one cycle → IDLE.
- `stk_write` and `stk_read` are never high together and are never high outside PUSH/POP.
- `count` never exceeds DEPTH and never wraps below 0.
- Sticky flags clear only on `reset`.
- `stk_data_in` holds its last pushed value between pushes.

## Timing
- Reset (at a clock edge with `reset`=1), regardless of state, sets:
  - state=IDLE
  - `busy`, `ret_valid`, `stk_write`, `stk_read` = 0
  - `ret_addr`, `stk_data_in`, `count` = 0
  - all flags = 0
- Stack contents are not cleared; the stack is treated as logically empty.
- Reset during POP or WAIT aborts the pop; no `ret_valid` is issued.
- CALL: request sampled at edge E0 → `stk_write` high during E0–E1 → count updated at E1 → `busy` low after E1. A new request is accepted at E2.
- RET: sampled at E0 → `stk_read` high during E0–E1 → `ret_addr` captured at edge E(1+RD_LAT) → `ret_valid` high for the following cycle → IDLE at E(2+RD_LAT).
- RET latency is RD_LAT+2 cycles; with RD_LAT=1, `ret_valid` is high in the 3rd cycle after the request edge.
- Flags set at the edge where the offending request is sampled and are visible the next cycle.

## Test plan
- Reset, then CALL with `pc_next`=32'h12345678 → `stk_write` pulses for 1 cycle with `stk_data_in`=32'h12345678; count=1; `busy` high for 1 cycle.
- CALLs with 32'h12345678, 32'hAABBCCDD, 32'h11223344, then RET ×3 against a Stack model with RD_LAT=1 → `ret_addr` = 32'h11223344, 32'hAABBCCDD, 32'h12345678. Each `ret_valid` is high 3 cycles after its request; count ends at 0.
- RET on an empty stack → `underflow`=1; no `stk_read`; no `ret_valid`; count stays 0.
- DEPTH=4: 5 CALLs → 4 `stk_write` pulses, `overflow`=1, count=4.
- `call`=`ret`=1 in IDLE → `illegal`=1, no strobes. `call` asserted while `busy` → ignored, count unchanged.
- `reset` asserted in the WAIT cycle → next cycle all outputs 0, no `ret_valid`. A subsequent RET → `underflow`=1.
